// File: rtl/uv_clk_gate_mc.sv
`default_nettype none
// ============================================================================
//  Module   : uv_clk_gate_mc
//  Brief    : Multi-channel idle-driven clock gate. Each channel runs an
//             ON/IDLE/OFF/WAKE controller that gates its clock after a
//             programmable run of idle cycles and reopens it on activity,
//             force-on or a wake request (acknowledged once stable).
//  Revision : 1.0  initial release
// ============================================================================
module uv_clk_gate_mc #(
  parameter int CH_NUM   = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_DLY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*CH_NUM-1:0]   cfg_mode,
  input  logic [CNT_W-1:0]      cfg_idle_thr,
  input  logic [CH_NUM-1:0]     ch_busy,
  input  logic [CH_NUM-1:0]     wake_req,
  output logic [CH_NUM-1:0]     wake_ack,
  output logic [CH_NUM-1:0]     ch_on,
  output logic [CH_NUM-1:0]     clk_out
);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } state_t;

  // Wake counter value on the last WAKE cycle.
  localparam logic [3:0] C_WAKE_LAST = 4'(WAKE_DLY - 1);

  localparam logic [1:0] C_MODE_FORCE_ON  = 2'b01;
  localparam logic [1:0] C_MODE_FORCE_OFF = 2'b10;

  // A zero threshold behaves like one: gate after a single idle cycle.
  logic [CNT_W-1:0] w_thr_eff;
  assign w_thr_eff = (cfg_idle_thr == '0) ? CNT_W'(1) : cfg_idle_thr;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_wcnt;
    logic             r_on;
    logic             r_ack;

    logic [1:0]       w_mode;
    logic             w_force_on;
    logic             w_force_off;
    logic             w_auto;
    logic             w_idle;
    logic             w_wake_cond;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             w_thr_hit;

    assign w_mode      = cfg_mode[2*i +: 2];
    assign w_force_on  = (w_mode == C_MODE_FORCE_ON);
    assign w_force_off = (w_mode == C_MODE_FORCE_OFF);
    // Both 00 and 11 mean auto.
    assign w_auto      = ~w_force_on & ~w_force_off;
    assign w_idle      = w_auto & ~ch_busy[i] & ~wake_req[i];
    assign w_wake_cond = wake_req[i] | w_force_on | (w_auto & ch_busy[i]);

    // Compare in CNT_W+1 bits so cnt+1 never wraps before the threshold test.
    assign w_cnt_inc   = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    assign w_cnt_sat   = (&r_cnt) ? r_cnt : (r_cnt + CNT_W'(1));
    assign w_thr_hit   = (w_cnt_inc >= {1'b0, w_thr_eff});

    // Per-channel gating controller with registered enable and ack.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_ON;
        r_cnt   <= '0;
        r_wcnt  <= 4'd0;
        r_on    <= 1'b1;
        r_ack   <= 1'b0;
      end else begin
        r_ack <= 1'b0;
        if (w_force_off) begin
          // Force-off wins over everything, including a pending wake request.
          r_state <= ST_OFF;
          r_cnt   <= '0;
          r_on    <= 1'b0;
        end else begin
          case (r_state)
            ST_ON, ST_IDLE: begin
              if (w_force_on || !w_idle) begin
                r_state <= ST_ON;
                r_cnt   <= '0;
                r_on    <= 1'b1;
                // Clock already running: ack right away; the guard keeps a
                // request that is still high one cycle later from re-acking.
                r_ack   <= wake_req[i] & ~r_ack;
              end else if (w_thr_hit) begin
                r_state <= ST_OFF;
                r_cnt   <= '0;
                r_on    <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
                r_cnt   <= w_cnt_sat;
                r_on    <= 1'b1;
              end
            end
            ST_OFF: begin
              if (w_wake_cond) begin
                r_state <= ST_WAKE;
                r_wcnt  <= 4'd0;
                r_on    <= 1'b1;
              end else begin
                r_on    <= 1'b0;
              end
            end
            ST_WAKE: begin
              r_on <= 1'b1;
              if (r_wcnt == C_WAKE_LAST) begin
                r_state <= ST_ON;
                r_cnt   <= '0;
                // Only a requester gets an ack; busy/force-on wakes are silent.
                r_ack   <= wake_req[i];
              end else begin
                r_wcnt  <= r_wcnt + 4'd1;
              end
            end
            default: begin
              r_state <= ST_ON;
              r_cnt   <= '0;
              r_on    <= 1'b1;
            end
          endcase
        end
      end
    end

    assign ch_on[i]    = r_on;
    assign wake_ack[i] = r_ack;

`ifdef FPGA
    // Clock runs ungated; ch_on remains available as a status/enable.
    assign clk_out[i] = clk;
`elsif ASIC
    // Library integrated clock-gate cell, one per channel.
    uv_ckg_cell u_ckg (
      .clk  (clk),
      .en   (r_on),
      .gclk (clk_out[i])
    );
`else
    logic r_en_lat;

    // Enable latch, transparent while clk is low, so clk_out never glitches.
    always_latch begin
      if (!rst_n) begin
        r_en_lat = 1'b1;
      end else if (!clk) begin
        r_en_lat = r_on;
      end
    end

    assign clk_out[i] = clk & r_en_lat;
`endif
  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_uv_clk_gate_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uv_clk_gate_mc
//  Brief    : Directed self-checking bench for uv_clk_gate_mc (4 channels).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uv_clk_gate_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_mode;
  logic [7:0] cfg_idle_thr;
  logic [3:0] ch_busy;
  logic [3:0] wake_req;
  logic [3:0] wake_ack;
  logic [3:0] ch_on;
  logic [3:0] clk_out;

  int checks = 0;
  int errors = 0;

  uv_clk_gate_mc #(
    .CH_NUM   (4),
    .CNT_W    (8),
    .WAKE_DLY (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_mode     (cfg_mode),
    .cfg_idle_thr (cfg_idle_thr),
    .ch_busy      (ch_busy),
    .wake_req     (wake_req),
    .wake_ack     (wake_ack),
    .ch_on        (ch_on),
    .clk_out      (clk_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independence phase: ch0 auto, ch1 force-on, ch2 force-off, ch3 auto, thr=2.
  logic [3:0] ind_busy [7] = '{4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] ind_on   [7] = '{4'b1011, 4'b1010, 4'b1011, 4'b0011, 4'b0011, 4'b0011, 4'b0010};

  initial begin
    rst_n        = 1'b0;
    cfg_mode     = 8'h00;
    cfg_idle_thr = 8'd3;
    ch_busy      = 4'b1111;
    wake_req     = 4'b0000;

    // Reset values
    tick();
    chk("rst_ch_on",   ch_on,    4'b1111);
    chk("rst_ack",     wake_ack, 4'b0000);
    chk("rst_clk_out", clk_out,  4'b1111);

    rst_n = 1'b1;
    tick();
    chk("busy_hold_on", ch_on, 4'b1111);

    // Auto gating with threshold 3; ch0 gets one busy cycle after 2 idle ones
    ch_busy = 4'b0000;
    tick();
    chk("idle_e1", ch_on, 4'b1111);
    tick();
    chk("idle_e2", ch_on, 4'b1111);
    ch_busy = 4'b0001;
    tick();
    chk("idle_e3_gate",     ch_on,   4'b0001);
    chk("no_partial_pulse", clk_out, 4'b1111);
    ch_busy = 4'b0000;
    tick();
    chk("clk_out_gated", clk_out, 4'b0001);
    chk("restart_e1",    ch_on,   4'b0001);
    tick();
    chk("restart_e2",      ch_on, 4'b0001);
    tick();
    chk("restart_e3_gate", ch_on, 4'b0000);
    tick();
    chk("all_clk_out_low", clk_out, 4'b0000);

    // Wake handshake on channel 1
    wake_req = 4'b0010;
    tick();
    chk("wake_ch_on",      ch_on,    4'b0010);
    chk("wake_ack_early0", wake_ack, 4'b0000);
    tick();
    chk("wake_ack_early1", wake_ack, 4'b0000);
    chk("wake_clk_out",    clk_out,  4'b0010);
    tick();
    chk("wake_ack_pulse",  wake_ack, 4'b0010);
    wake_req = 4'b0000;
    tick();
    chk("wake_ack_single", wake_ack, 4'b0000);
    chk("wake_stays_on",   ch_on,    4'b0010);
    tick();
    chk("wake_idle_on",    ch_on,    4'b0010);
    // Request while clock is already running: immediate ack
    wake_req = 4'b0010;
    tick();
    chk("run_ack_pulse", wake_ack, 4'b0010);
    wake_req = 4'b0000;
    tick();
    chk("run_ack_single", wake_ack, 4'b0000);
    chk("run_ack_on",     ch_on,    4'b0010);

    // Force-off: ch1 directly, ch2 during WAKE
    cfg_mode = 8'h08;
    wake_req = 4'b0100;
    tick();
    chk("foff_ch1_wake_ch2", ch_on, 4'b0100);
    cfg_mode = 8'h28;
    tick();
    chk("foff_in_wake",     ch_on,    4'b0000);
    chk("foff_in_wake_ack", wake_ack, 4'b0000);
    tick();
    chk("foff_ignores_req", ch_on,    4'b0000);
    chk("foff_no_ack",      wake_ack, 4'b0000);

    // Force-on from OFF on ch3
    wake_req = 4'b0000;
    cfg_mode = 8'h68;
    tick();
    chk("fon_wake_e1", ch_on, 4'b1000);
    tick();
    chk("fon_wake_e2", ch_on, 4'b1000);
    tick();
    chk("fon_on",      ch_on,    4'b1000);
    chk("fon_no_ack",  wake_ack, 4'b0000);
    repeat (5) tick();
    chk("fon_never_gates", ch_on, 4'b1000);

    // Asynchronous reset in the clk-low phase
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ch_on",   ch_on,    4'b1111);
    chk("async_rst_ack",     wake_ack, 4'b0000);
    chk("async_rst_clk_low", clk_out,  4'b0000);
    cfg_mode     = 8'h24;
    cfg_idle_thr = 8'd2;
    wake_req     = 4'b0100;
    ch_busy      = 4'b0000;
    tick();
    chk("clk_out_resumes", clk_out, 4'b1111);
    rst_n = 1'b1;

    // Channel independence
    for (int k = 0; k < 7; k++) begin
      ch_busy = ind_busy[k];
      tick();
      chk($sformatf("indep_on_e%0d", k + 1), ch_on, ind_on[k]);
      chk($sformatf("indep_ack_e%0d", k + 1), wake_ack, 4'b0000);
    end

    // Zero threshold acts as one: ch1 back to auto gates after one idle edge
    ch_busy      = 4'b0000;
    wake_req     = 4'b0000;
    cfg_idle_thr = 8'd0;
    cfg_mode     = 8'h20;
    tick();
    chk("thr_zero_gate", ch_on, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
